// File: rtl/not_gate_checker_if.sv
// Stimulus/response and result bus of the NOT-gate checker.
// The master side (test driver) applies start and samples and reads back
// results; the slave side (not_gate_checker) consumes samples and reports.
interface not_gate_checker_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             smp_valid;
  logic             a;
  logic             y;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic             err;
  logic [CNT_W-1:0] ff_idx;
  logic             ff_a;

  modport master (
    output start, smp_valid, a, y,
    input  busy, done, pass, pass_cnt, fail_cnt, err, ff_idx, ff_a
  );

  modport slave (
    input  start, smp_valid, a, y,
    output busy, done, pass, pass_cnt, fail_cnt, err, ff_idx, ff_a
  );
endinterface

// File: rtl/not_gate_checker.sv
// NOT-gate checker: counts stimulus/response samples with y == ~a (pass)
// and y != ~a (fail) over a run of N_VECTORS accepted samples.
// FSM IDLE -> RUN -> DONE, restartable from DONE; all outputs registered.
// Optional feature macro NOT_GATE_CHECKER_FIRST_FAIL_EN: when defined, the
// index and stimulus value of the first failing sample of a run are
// captured on ff_idx/ff_a; otherwise those outputs are tied to 0.
module not_gate_checker #(
  parameter int N_VECTORS = 4,
  parameter int CNT_W     = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  not_gate_checker_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_VECTORS - 1);

  // Counters stop at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == CNT_MAX) begin
      r = v;
    end else begin
      r = v + CNT_ONE;
    end
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             run_entry_s;
  logic             accept_s;
  logic             smp_ok_s;
`ifdef NOT_GATE_CHECKER_FIRST_FAIL_EN
  logic [CNT_W-1:0] ff_idx_q, ff_idx_d;
  logic             ff_a_q, ff_a_d;
`endif

  // Next-state, run bookkeeping and registered-output values.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pass_cnt_d  = pass_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    err_d       = err_q;
    run_entry_s = 1'b0;
    accept_s    = 1'b0;
    smp_ok_s    = (bus.y == ~bus.a);
`ifdef NOT_GATE_CHECKER_FIRST_FAIL_EN
    ff_idx_d    = ff_idx_q;
    ff_a_d      = ff_a_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          run_entry_s = 1'b1;
          state_d     = S_RUN;
        end else begin
          state_d     = S_IDLE;
        end
      end
      S_RUN: begin
        // start is deliberately ignored here: a run is never restarted.
        if (bus.smp_valid) begin
          accept_s = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (bus.start) begin
          run_entry_s = 1'b1;
          state_d     = S_RUN;
        end else begin
          state_d     = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (run_entry_s) begin
      idx_d      = CNT_ZERO;
      pass_cnt_d = CNT_ZERO;
      fail_cnt_d = CNT_ZERO;
      err_d      = 1'b0;
`ifdef NOT_GATE_CHECKER_FIRST_FAIL_EN
      ff_idx_d   = CNT_ZERO;
      ff_a_d     = 1'b0;
`endif
    end else if (accept_s) begin
      idx_d = sat_inc(idx_q);
      if (smp_ok_s) begin
        pass_cnt_d = sat_inc(pass_cnt_q);
      end else begin
        fail_cnt_d = sat_inc(fail_cnt_q);
        err_d      = 1'b1;
`ifdef NOT_GATE_CHECKER_FIRST_FAIL_EN
        // err_q still clear means this is the first failure of the run.
        if (!err_q) begin
          ff_idx_d = idx_q;
          ff_a_d   = bus.a;
        end else begin
          ff_idx_d = ff_idx_q;
          ff_a_d   = ff_a_q;
        end
`endif
      end
    end else begin
      idx_d = idx_q;
    end

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
    pass_d = done_d && (fail_cnt_d == CNT_ZERO);
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= CNT_ZERO;
      pass_cnt_q <= CNT_ZERO;
      fail_cnt_q <= CNT_ZERO;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
`ifdef NOT_GATE_CHECKER_FIRST_FAIL_EN
      ff_idx_q   <= CNT_ZERO;
      ff_a_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
`ifdef NOT_GATE_CHECKER_FIRST_FAIL_EN
      ff_idx_q   <= ff_idx_d;
      ff_a_q     <= ff_a_d;
`endif
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.pass_cnt = pass_cnt_q;
  assign bus.fail_cnt = fail_cnt_q;
  assign bus.err      = err_q;
`ifdef NOT_GATE_CHECKER_FIRST_FAIL_EN
  assign bus.ff_idx   = ff_idx_q;
  assign bus.ff_a     = ff_a_q;
`else
  assign bus.ff_idx   = {CNT_W{1'b0}};
  assign bus.ff_a     = 1'b0;
`endif

endmodule
